// File: rtl/prio_pkg.sv
// Shared definitions for the switch debouncer and its downstream priority encoder.
//   DATA_W              : number of switch/button lanes
//   DEBOUNCE_CYCLES_DEF : default debounce length in clocks
//   db_state_e          : per-lane debounce state
package prio_pkg;

  localparam int unsigned DATA_W              = 8;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } db_state_e;

endpackage

// File: rtl/debounce_bit.sv
// One debounce lane: 2-flop synchronizer, saturating counter and STABLE/PENDING FSM.
// Optional feature macro: STICKY_EN (sticky-set data bit with clear input).
// Ports:
//   clk_i        : clock, all state on rising edge
//   rst_i        : synchronous active-high reset
//   raw_i        : asynchronous raw level
//   clr_i        : sticky clear (STICKY_EN only)
//   data_o       : debounced level
//   upd_o        : data bit takes a new value on the coming edge
//   pending_d_o  : lane will be PENDING after the coming edge
module debounce_bit
  import prio_pkg::*;
#(
  parameter int unsigned DebounceCycles = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
`ifdef STICKY_EN
  input  logic clr_i,
`endif
  output logic data_o,
  output logic upd_o,
  output logic pending_d_o
);

  localparam int unsigned CntW = $clog2(DebounceCycles);
  localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

  logic            s1_q, s2_q;
  logic            data_q, data_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  db_state_e       state_q, state_d;
  logic            commit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      STABLE: begin
        if (s2_q != data_q) begin
          state_d = PENDING;
          cnt_d   = CntW'(1);
        end
      end
      PENDING: begin
        if (s2_q == data_q) begin
          // Glitch shorter than the debounce window: drop it.
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          // This edge would make the count reach DebounceCycles.
          commit  = 1'b1;
          state_d = STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    data_d = data_q;
`ifdef STICKY_EN
    // Only rising commits set the bit; a same-edge set beats clr.
    if (clr_i) data_d = 1'b0;
    if (commit && s2_q) data_d = 1'b1;
`else
    if (commit) data_d = s2_q;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      data_q  <= 1'b0;
      cnt_q   <= '0;
      state_q <= STABLE;
    end else begin
      s1_q    <= raw_i;
      s2_q    <= s1_q;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign data_o      = data_q;
  assign upd_o       = (data_d != data_q);
  assign pending_d_o = (state_d == PENDING);

endmodule

// File: rtl/switch_debouncer.sv
// 8-lane switch debouncer feeding a priority encoder.
// Optional feature macro: STICKY_EN (sticky data bits plus clr input).
// Ports:
//   clk     : clock, all state on rising edge
//   rst     : synchronous active-high reset
//   raw     : asynchronous switch levels, bit 7 highest priority downstream
//   clr     : sticky clear (STICKY_EN only)
//   data    : debounced levels
//   changed : one-cycle pulse the first cycle data shows a new value
//   stable  : high when no lane has a pending transition
module switch_debouncer
  import prio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] raw,
`ifdef STICKY_EN
  input  logic              clr,
`endif
  output logic [DATA_W-1:0] data,
  output logic              changed,
  output logic              stable
);

  logic [DATA_W-1:0] upd;
  logic [DATA_W-1:0] pend_d;
  logic              changed_q;
  logic              stable_q;

  for (genvar b = 0; b < DATA_W; b++) begin : g_bit
    debounce_bit #(
      .DebounceCycles(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk_i      (clk),
      .rst_i      (rst),
      .raw_i      (raw[b]),
`ifdef STICKY_EN
      .clr_i      (clr),
`endif
      .data_o     (data[b]),
      .upd_o      (upd[b]),
      .pending_d_o(pend_d[b])
    );
  end

  // Lanes updating on the same edge merge into one pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      changed_q <= 1'b0;
      stable_q  <= 1'b1;
    end else begin
      changed_q <= |upd;
      stable_q  <= ~|pend_d;
    end
  end

  assign changed = changed_q;
  assign stable  = stable_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer with DEBOUNCE_CYCLES = 4.
module tb_switch_debouncer;

  localparam int unsigned DC = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] raw = 8'h00;
  logic       clr = 1'b0;
  logic [7:0] data;
  logic       changed;
  logic       stable;

  always #5 clk = ~clk;

  switch_debouncer #(
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .raw    (raw),
`ifdef STICKY_EN
    .clr    (clr),
`endif
    .data   (data),
    .changed(changed),
    .stable (stable)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: each lane sees raw two edges late; it follows once the seen
  // level has disagreed with data for DC edges in a row.
  logic [7:0] m_s1 = '0, m_s2 = '0, m_data = '0;
  logic       m_ch = 1'b0, m_st = 1'b1;
  int         m_run [8];

  task automatic model_step(input logic r, input logic [7:0] rw, input logic cl);
    logic [7:0] seen, nxt, set;
    bit all_quiet;
    if (r) begin
      m_s1 = '0; m_s2 = '0; m_data = '0; m_ch = 1'b0; m_st = 1'b1;
      for (int b = 0; b < 8; b++) m_run[b] = 0;
      return;
    end
    seen = m_s2;
    m_s2 = m_s1;
    m_s1 = rw;
    nxt  = m_data;
    set  = '0;
    for (int b = 0; b < 8; b++) begin
      if (seen[b] == m_data[b]) begin
        m_run[b] = 0;
      end else if (m_run[b] + 1 >= DC) begin
        m_run[b] = 0;
`ifdef STICKY_EN
        if (seen[b]) begin nxt[b] = 1'b1; set[b] = 1'b1; end
`else
        nxt[b] = seen[b];
`endif
      end else begin
        m_run[b] = m_run[b] + 1;
      end
    end
`ifdef STICKY_EN
    if (cl) nxt = nxt & set;
`else
    if (cl) set = set;
`endif
    all_quiet = 1'b1;
    for (int b = 0; b < 8; b++) if (m_run[b] != 0) all_quiet = 1'b0;
    m_ch   = (nxt != m_data);
    m_data = nxt;
    m_st   = all_quiet;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One edge: drive, clock, advance model, compare against model.
  task automatic cycle(input logic r, input logic [7:0] rw, input logic cl);
    rst = r; raw = rw; clr = cl;
    @(posedge clk);
    model_step(r, rw, cl);
    #1;
    check("model_data", data, m_data);
    check("model_changed", {7'd0, changed}, {7'd0, m_ch});
    check("model_stable", {7'd0, stable}, {7'd0, m_st});
  endtask

  typedef struct {
    logic       r;
    logic [7:0] rw;
    logic [7:0] d;
    logic       c;
    logic       s;
  } vec_t;
  vec_t vec[$];

  task automatic add(input logic r, input logic [7:0] rw, input logic [7:0] d,
                     input logic c, input logic s, input int n);
    vec_t v;
    v.r = r; v.rw = rw; v.d = d; v.c = c; v.s = s;
    for (int i = 0; i < n; i++) vec.push_back(v);
  endtask

  initial begin
    for (int b = 0; b < 8; b++) m_run[b] = 0;

`ifndef STICKY_EN
    // Reset with raw high, then settle.
    add(1, 8'hFF, 8'h00, 0, 1, 2);
    add(0, 8'h00, 8'h00, 0, 1, 2);
    // Clean commit of bit 7 on the 6th edge.
    add(0, 8'h80, 8'h00, 0, 1, 2);
    add(0, 8'h80, 8'h00, 0, 0, 3);
    add(0, 8'h80, 8'h80, 1, 1, 1);
    add(0, 8'h80, 8'h80, 0, 1, 1);
    // Bit 3 glitch lasting 3 clocks is rejected.
    add(0, 8'h88, 8'h80, 0, 1, 2);
    add(0, 8'h88, 8'h80, 0, 0, 1);
    add(0, 8'h80, 8'h80, 0, 0, 2);
    add(0, 8'h80, 8'h80, 0, 1, 2);
    // Release bit 7.
    add(0, 8'h00, 8'h80, 0, 1, 2);
    add(0, 8'h00, 8'h80, 0, 0, 3);
    add(0, 8'h00, 8'h00, 1, 1, 1);
    add(0, 8'h00, 8'h00, 0, 1, 1);
    // Two bits commit together: one pulse.
    add(0, 8'h21, 8'h00, 0, 1, 2);
    add(0, 8'h21, 8'h00, 0, 0, 3);
    add(0, 8'h21, 8'h21, 1, 1, 1);
    add(0, 8'h21, 8'h21, 0, 1, 1);
    // Reset on the 4th edge of a pending change restarts the full latency.
    add(0, 8'h04, 8'h21, 0, 1, 2);
    add(0, 8'h04, 8'h21, 0, 0, 1);
    add(1, 8'h04, 8'h00, 0, 1, 1);
    add(0, 8'h04, 8'h00, 0, 1, 2);
    add(0, 8'h04, 8'h00, 0, 0, 3);
    add(0, 8'h04, 8'h04, 1, 1, 1);
    add(0, 8'h04, 8'h04, 0, 1, 1);

    foreach (vec[i]) begin
      cycle(vec[i].r, vec[i].rw, 1'b0);
      check($sformatf("vec%0d_data", i), data, vec[i].d);
      check($sformatf("vec%0d_changed", i), {7'd0, changed}, {7'd0, vec[i].c});
      check($sformatf("vec%0d_stable", i), {7'd0, stable}, {7'd0, vec[i].s});
    end
`else
    // Sticky: rising commit sets, falling commit ignored, clr clears.
    cycle(1, 8'hFF, 0);
    cycle(1, 8'hFF, 0);
    check("sticky_reset_data", data, 8'h00);
    for (int i = 0; i < 6; i++) cycle(0, 8'h10, 0);
    check("sticky_set_data", data, 8'h10);
    check("sticky_set_changed", {7'd0, changed}, 8'h01);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 8'h00, 0);
      check("sticky_hold_data", data, 8'h10);
      check("sticky_hold_changed", {7'd0, changed}, 8'h00);
    end
    cycle(0, 8'h00, 1);
    check("sticky_clr_data", data, 8'h00);
    check("sticky_clr_changed", {7'd0, changed}, 8'h01);
    cycle(0, 8'h00, 0);
    check("sticky_after_clr_changed", {7'd0, changed}, 8'h00);
`endif

    // Random phase: lanes toggle occasionally, with rare resets.
    begin
      logic [7:0] rw;
      logic       r, cl;
      rw = 8'h00;
      for (int i = 0; i < 3000; i++) begin
        for (int b = 0; b < 8; b++)
          if ($urandom_range(0, 9) == 0) rw[b] = ~rw[b];
        r  = ($urandom_range(0, 249) == 0);
`ifdef STICKY_EN
        cl = ($urandom_range(0, 39) == 0);
`else
        cl = 1'b0;
`endif
        cycle(r, rw, cl);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
